// File: rtl/regfile_pkg.sv
// Register-file geometry shared by the regfile and its write arbiter.
package regfile_pkg;

  localparam int ADDR_WIDTH = 5;
  localparam int DATA_WIDTH = 32;

  localparam logic [ADDR_WIDTH-1:0] REG_ZERO = '0;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant searched upward from a rotating pointer.
module rr_arbiter #(
  parameter int N = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  input  logic         enable,
  input  logic         advance,
  output logic [N-1:0] grant
);

  localparam int PW = $clog2(N);

  logic [PW-1:0] ptr_q;
  logic [PW-1:0] ptr_d;
  logic          found;
  int            idx;

  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(ptr_q) + k) % N;
      if (enable && !found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    for (int i = 0; i < N; i++) begin
      if (grant[i]) ptr_d = PW'((i + 1) % N);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else if (advance) begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares the regfile write port among writeback requesters through a
// one-entry output stage, and flags read-after-write hazards on it.
module regfile_write_arbiter
  import regfile_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int AW      = ADDR_WIDTH,
  parameter int DW      = DATA_WIDTH
) (
  input  logic                  Clk,
  input  logic                  ResetN,
  input  logic [NUM_REQ-1:0]    ReqValid,
  output logic [NUM_REQ-1:0]    ReqReady,
  input  logic [NUM_REQ*AW-1:0] ReqAddr,
  input  logic [NUM_REQ*DW-1:0] ReqData,
  input  logic                  WritePortHold,
  output logic [AW-1:0]         WriteRegister,
  output logic [DW-1:0]         WriteData,
  output logic                  RegWrite,
  input  logic [AW-1:0]         ReadRegister1,
  input  logic [AW-1:0]         ReadRegister2,
  output logic                  Hazard1,
  output logic                  Hazard2
);

  logic [NUM_REQ-1:0] grant;
  logic               hs;
  logic [AW-1:0]      hs_addr;
  logic [DW-1:0]      hs_data;

  logic               vld_q, vld_d;
  logic [AW-1:0]      addr_q, addr_d;
  logic [DW-1:0]      data_q, data_d;

  // Gating with ResetN keeps ReqReady low while reset is asserted.
  rr_arbiter #(
    .N(NUM_REQ)
  ) u_arb (
    .clk    (Clk),
    .rst_n  (ResetN),
    .req    (ReqValid),
    .enable (~WritePortHold & ResetN),
    .advance(hs),
    .grant  (grant)
  );

  assign hs = |grant;

  always_comb begin
    hs_addr = '0;
    hs_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        hs_addr = hs_addr | ReqAddr[i*AW +: AW];
        hs_data = hs_data | ReqData[i*DW +: DW];
      end
    end
  end

  // r0 writes complete the handshake but never occupy the stage.
  always_comb begin
    vld_d  = vld_q;
    addr_d = addr_q;
    data_d = data_q;
    if (!WritePortHold) begin
      vld_d = hs && (hs_addr != AW'(REG_ZERO));
      if (vld_d) begin
        addr_d = hs_addr;
        data_d = hs_data;
      end
    end
  end

  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      vld_q  <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
    end else begin
      vld_q  <= vld_d;
      addr_q <= addr_d;
      data_q <= data_d;
    end
  end

  assign ReqReady      = grant;
  assign WriteRegister = addr_q;
  assign WriteData     = data_q;
  assign RegWrite      = vld_q & ~WritePortHold;
  assign Hazard1       = vld_q & (ReadRegister1 == addr_q);
  assign Hazard2       = vld_q & (ReadRegister2 == addr_q);

endmodule
